imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 48 ++++
 rtl/imem_arbiter.sv | 102 ++++++++++
 tb/tb_imem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and memory-side signals of the instruction
// memory arbiter. The arbiter uses the slave view; the requesters and the
// memory model together use the master view.
interface imem_arbiter_if;
  logic        boot_hold;

  logic        f_req_valid;
  logic [31:0] f_req_addr;
  logic        f_req_ready;
  logic        f_rsp_valid;
  logic        f_rsp_err;
  logic [31:0] f_rsp_data;

  logic        l_req_valid;
  logic        l_req_we;
  logic [31:0] l_req_addr;
  logic [31:0] l_req_wdata;
  logic        l_req_ready;
  logic        l_rsp_valid;
  logic        l_rsp_err;
  logic [31:0] l_rsp_data;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  boot_hold,
    input  f_req_valid, f_req_addr,
    output f_req_ready, f_rsp_valid, f_rsp_err, f_rsp_data,
    input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
    output l_req_ready, l_rsp_valid, l_rsp_err, l_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output boot_hold,
    output f_req_valid, f_req_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_err, f_rsp_data,
    output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
    input  l_req_ready, l_rsp_valid, l_rsp_err, l_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: shares one single-port memory between the
// instruction fetch port and the program loader. The loader wins ties until
// it has starved a pending fetch for MAX_STREAK consecutive grants. Each
// accepted request gets exactly one response, one cycle later, on its own
// port; out-of-range or misaligned requests are answered with an error
// without touching memory.
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned MEM_BYTES  = 16384,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  // Last legal word address, computed one bit wider so a memory placed at
  // the top of the address space cannot wrap the upper bound.
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_BYTES) - 33'd4;

  logic [SW-1:0] streak_q, streak_d;
  logic          fRspValid_q, fRspValid_d;
  logic          lRspValid_q, lRspValid_d;
  logic          rspErr_q, rspErr_d;
  logic          rspRead_q, rspRead_d;

  logic          fetchElig, loadElig;
  logic          grantF, grantL, accept;
  logic [31:0]   selAddr;
  logic          addrLegal, isWrite;

  // Arbitration: loader has priority unless it has used up its streak while a
  // fetch is waiting; nothing is granted while reset is held.
  always_comb begin
    fetchElig = bus.f_req_valid & ~bus.boot_hold & ~rst;
    loadElig  = bus.l_req_valid & ~rst;
    grantL    = loadElig & (~fetchElig | (streak_q != STREAK_MAX));
    grantF    = fetchElig & ~grantL;
    accept    = grantL | grantF;
  end

  // Address decode of the granted request and the memory strobe outputs.
  always_comb begin
    selAddr   = grantL ? bus.l_req_addr : bus.f_req_addr;
    addrLegal = (selAddr[1:0] == 2'b00)
              && ({1'b0, selAddr} >= {1'b0, BASE_ADDR})
              && ({1'b0, selAddr} <= LAST_ADDR);
    isWrite   = grantL & bus.l_req_we;

    bus.f_req_ready = grantF;
    bus.l_req_ready = grantL;
    bus.mem_en      = accept & addrLegal;
    bus.mem_we      = accept & addrLegal & isWrite;
    bus.mem_addr    = selAddr - BASE_ADDR;
    bus.mem_wdata   = bus.l_req_wdata;
  end

  // Next-state for the starvation counter and the one-deep response stage.
  always_comb begin
    streak_d = streak_q;
    if (grantF || !fetchElig) begin
      streak_d = '0;
    end else if (grantL && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end

    fRspValid_d = grantF;
    lRspValid_d = grantL;
    rspErr_d    = accept & ~addrLegal;
    rspRead_d   = accept & addrLegal & ~isWrite;
  end

  // State registers; reset also drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q    <= '0;
      fRspValid_q <= 1'b0;
      lRspValid_q <= 1'b0;
      rspErr_q    <= 1'b0;
      rspRead_q   <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      fRspValid_q <= fRspValid_d;
      lRspValid_q <= lRspValid_d;
      rspErr_q    <= rspErr_d;
      rspRead_q   <= rspRead_d;
    end
  end

  // Response outputs: memory read data only for legal reads, zero otherwise.
  always_comb begin
    bus.f_rsp_valid = fRspValid_q;
    bus.f_rsp_err   = fRspValid_q & rspErr_q;
    bus.f_rsp_data  = (fRspValid_q & rspRead_q) ? bus.mem_rdata : 32'h0;
    bus.l_rsp_valid = lRspValid_q;
    bus.l_rsp_err   = lRspValid_q & rspErr_q;
    bus.l_rsp_data  = (lRspValid_q & rspRead_q) ? bus.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a small behavioural memory
// attached to the memory side of the interface.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  imem_arbiter_if ifc ();

  imem_arbiter #(
    .BASE_ADDR (32'h8000_0000),
    .MEM_BYTES (16384),
    .MAX_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency, write on strobe.
  logic [31:0] memArr [0:4095];
  always @(posedge clk) begin
    if (ifc.mem_en) begin
      if (ifc.mem_we) memArr[ifc.mem_addr[13:2]] <= ifc.mem_wdata;
      ifc.mem_rdata <= memArr[ifc.mem_addr[13:2]];
    end
  end

  task automatic idle_inputs();
    ifc.boot_hold   = 1'b0;
    ifc.f_req_valid = 1'b0;
    ifc.f_req_addr  = 32'h0;
    ifc.l_req_valid = 1'b0;
    ifc.l_req_we    = 1'b0;
    ifc.l_req_addr  = 32'h0;
    ifc.l_req_wdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifc.f_req_valid = 1'b1;
    ifc.f_req_addr  = 32'h8000_0000;
    ifc.l_req_valid = 1'b1;
    ifc.l_req_addr  = 32'h8000_0004;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (ifc.f_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_f_ready got %b exp 0", ifc.f_req_ready); end
    checks++; if (ifc.l_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_l_ready got %b exp 0", ifc.l_req_ready); end
    checks++; if (ifc.mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en got %b exp 0", ifc.mem_en); end
    checks++; if (ifc.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %b exp 0", ifc.mem_we); end
    checks++; if ({ifc.f_rsp_valid, ifc.f_rsp_err, ifc.l_rsp_valid, ifc.l_rsp_err} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_flags got %b exp 0000", {ifc.f_rsp_valid, ifc.f_rsp_err, ifc.l_rsp_valid, ifc.l_rsp_err}); end
    checks++; if ({ifc.f_rsp_data, ifc.l_rsp_data} !== 64'h0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h exp 0", {ifc.f_rsp_data, ifc.l_rsp_data}); end
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_fetch_basic();
    // Loader seeds the word, then fetch reads it at 0x80000010.
    ifc.l_req_valid = 1'b1; ifc.l_req_we = 1'b1;
    ifc.l_req_addr = 32'h8000_0010; ifc.l_req_wdata = 32'h1234_5678;
    #1;
    checks++; if (ifc.l_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL seed_l_ready got %b exp 1", ifc.l_req_ready); end
    next_cycle();
    ifc.l_req_valid = 1'b0; ifc.l_req_we = 1'b0;
    checks++; if ({ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data} !== {2'b10, 32'h0}) begin errors++; $display("[TB] FAIL seed_l_rsp got v%b e%b %h exp v1 e0 0", ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data); end
    ifc.f_req_valid = 1'b1; ifc.f_req_addr = 32'h8000_0010;
    #1;
    checks++; if (ifc.f_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ready got %b exp 1", ifc.f_req_ready); end
    checks++; if ({ifc.mem_en, ifc.mem_we} !== 2'b10) begin errors++; $display("[TB] FAIL fetch_mem_strobes got %b exp 10", {ifc.mem_en, ifc.mem_we}); end
    checks++; if (ifc.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL fetch_mem_addr got %h exp 00000010", ifc.mem_addr); end
    next_cycle();
    ifc.f_req_valid = 1'b0;
    checks++; if ({ifc.f_rsp_valid, ifc.f_rsp_err} !== 2'b10) begin errors++; $display("[TB] FAIL fetch_rsp_flags got %b exp 10", {ifc.f_rsp_valid, ifc.f_rsp_err}); end
    checks++; if (ifc.f_rsp_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL fetch_rsp_data got %h exp 12345678", ifc.f_rsp_data); end
    checks++; if (ifc.l_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wrong_port got %b exp 0", ifc.l_rsp_valid); end
    next_cycle();
    checks++; if (ifc.f_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_rsp_pulse got %b exp 0", ifc.f_rsp_valid); end
  endtask

  task automatic test_write_then_fetch();
    ifc.l_req_valid = 1'b1; ifc.l_req_we = 1'b1;
    ifc.l_req_addr = 32'h8000_3FFC; ifc.l_req_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({ifc.l_req_ready, ifc.mem_en, ifc.mem_we} !== 3'b111) begin errors++; $display("[TB] FAIL top_write_strobes got %b exp 111", {ifc.l_req_ready, ifc.mem_en, ifc.mem_we}); end
    checks++; if (ifc.mem_addr !== 32'h3FFC) begin errors++; $display("[TB] FAIL top_write_addr got %h exp 00003ffc", ifc.mem_addr); end
    checks++; if (ifc.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL top_write_data got %h exp deadbeef", ifc.mem_wdata); end
    next_cycle();
    ifc.l_req_valid = 1'b0; ifc.l_req_we = 1'b0;
    ifc.f_req_valid = 1'b1; ifc.f_req_addr = 32'h8000_3FFC;
    #1;
    checks++; if ({ifc.f_req_ready, ifc.mem_en, ifc.mem_we} !== 3'b110) begin errors++; $display("[TB] FAIL top_read_strobes got %b exp 110", {ifc.f_req_ready, ifc.mem_en, ifc.mem_we}); end
    next_cycle();
    ifc.f_req_valid = 1'b0;
    checks++; if ({ifc.f_rsp_valid, ifc.f_rsp_err, ifc.f_rsp_data} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL top_read_rsp got v%b e%b %h exp v1 e0 deadbeef", ifc.f_rsp_valid, ifc.f_rsp_err, ifc.f_rsp_data); end
    next_cycle();
  endtask

  task automatic test_illegal();
    logic [31:0] badAddr [3];
    badAddr[0] = 32'h8000_4000;
    badAddr[1] = 32'h8000_0002;
    badAddr[2] = 32'h7FFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      ifc.f_req_valid = 1'b1; ifc.f_req_addr = badAddr[i];
      #1;
      checks++; if ({ifc.f_req_ready, ifc.mem_en} !== 2'b10) begin errors++; $display("[TB] FAIL illegal_accept[%0d] got ready/en %b exp 10", i, {ifc.f_req_ready, ifc.mem_en}); end
      next_cycle();
      ifc.f_req_valid = 1'b0;
      checks++; if ({ifc.f_rsp_valid, ifc.f_rsp_err, ifc.f_rsp_data} !== {2'b11, 32'h0}) begin errors++; $display("[TB] FAIL illegal_rsp[%0d] got v%b e%b %h exp v1 e1 0", i, ifc.f_rsp_valid, ifc.f_rsp_err, ifc.f_rsp_data); end
    end
    // Loader write just past the end must not reach memory.
    ifc.l_req_valid = 1'b1; ifc.l_req_we = 1'b1;
    ifc.l_req_addr = 32'h8000_4000; ifc.l_req_wdata = 32'h5555_AAAA;
    #1;
    checks++; if ({ifc.l_req_ready, ifc.mem_en, ifc.mem_we} !== 3'b100) begin errors++; $display("[TB] FAIL illegal_write got %b exp 100", {ifc.l_req_ready, ifc.mem_en, ifc.mem_we}); end
    next_cycle();
    ifc.l_req_valid = 1'b0; ifc.l_req_we = 1'b0;
    checks++; if ({ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data} !== {2'b11, 32'h0}) begin errors++; $display("[TB] FAIL illegal_write_rsp got v%b e%b %h exp v1 e1 0", ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data); end
    next_cycle();
  endtask

  task automatic test_streak();
    // 1 = loader granted, 0 = fetch granted, first cycle in the MSB.
    logic [9:0] expL;
    expL = 10'b11110_11110;
    ifc.f_req_valid = 1'b1; ifc.f_req_addr = 32'h8000_0000;
    ifc.l_req_valid = 1'b1; ifc.l_req_we = 1'b0; ifc.l_req_addr = 32'h8000_0004;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({ifc.l_req_ready, ifc.f_req_ready} !== {expL[9-i], ~expL[9-i]}) begin errors++; $display("[TB] FAIL streak_grant[%0d] got l%b f%b exp l%b f%b", i, ifc.l_req_ready, ifc.f_req_ready, expL[9-i], ~expL[9-i]); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_boot_hold();
    logic [4:0] expL;
    expL = 5'b11110;
    ifc.boot_hold = 1'b1;
    ifc.f_req_valid = 1'b1; ifc.f_req_addr = 32'h8000_0000;
    ifc.l_req_valid = 1'b1; ifc.l_req_we = 1'b0; ifc.l_req_addr = 32'h8000_0004;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if ({ifc.l_req_ready, ifc.f_req_ready} !== 2'b10) begin errors++; $display("[TB] FAIL hold_grant[%0d] got l%b f%b exp l1 f0", i, ifc.l_req_ready, ifc.f_req_ready); end
      next_cycle();
    end
    // Released: the streak must start from zero.
    ifc.boot_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({ifc.l_req_ready, ifc.f_req_ready} !== {expL[4-i], ~expL[4-i]}) begin errors++; $display("[TB] FAIL release_grant[%0d] got l%b f%b exp l%b f%b", i, ifc.l_req_ready, ifc.f_req_ready, expL[4-i], ~expL[4-i]); end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words[0] = 32'hA0A0_0001; words[1] = 32'hB1B1_0002;
    words[2] = 32'hC2C2_0003; words[3] = 32'hD3D3_0004;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++; if ({ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data} !== {2'b10, 32'h0}) begin errors++; $display("[TB] FAIL b2b_write_rsp[%0d] got v%b e%b %h exp v1 e0 0", i-1, ifc.l_rsp_valid, ifc.l_rsp_err, ifc.l_rsp_data); end
      end
      if (i < 4) begin
        ifc.l_req_valid = 1'b1; ifc.l_req_we = 1'b1;
        ifc.l_req_addr = 32'h8000_0100 + 32'(i * 4); ifc.l_req_wdata = words[i];
      end else begin
        ifc.l_req_valid = 1'b0; ifc.l_req_we = 1'b0;
      end
      next_cycle();
    end
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++; if ({ifc.f_rsp_valid, ifc.f_rsp_err, ifc.f_rsp_data} !== {2'b10, words[i-1]}) begin errors++; $display("[TB] FAIL b2b_read_rsp[%0d] got v%b e%b %h exp v1 e0 %h", i-1, ifc.f_rsp_valid, ifc.f_rsp_err, ifc.f_rsp_data, words[i-1]); end
      end
      if (i < 4) begin
        ifc.f_req_valid = 1'b1; ifc.f_req_addr = 32'h8000_0100 + 32'(i * 4);
      end else begin
        ifc.f_req_valid = 1'b0;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    ifc.f_req_valid = 1'b1; ifc.f_req_addr = 32'h8000_0010;
    #1;
    checks++; if ({ifc.f_req_ready, ifc.mem_en} !== 2'b11) begin errors++; $display("[TB] FAIL midrst_accept got %b exp 11", {ifc.f_req_ready, ifc.mem_en}); end
    @(posedge clk);
    rst = 1'b1;
    ifc.l_req_valid = 1'b1; ifc.l_req_addr = 32'h8000_0004;
    #1;
    checks++; if ({ifc.f_rsp_valid, ifc.l_rsp_valid, ifc.f_rsp_err, ifc.l_rsp_err} !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_rsp_flags got %b exp 0000", {ifc.f_rsp_valid, ifc.l_rsp_valid, ifc.f_rsp_err, ifc.l_rsp_err}); end
    checks++; if ({ifc.f_req_ready, ifc.l_req_ready, ifc.mem_en, ifc.mem_we} !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_strobes got %b exp 0000", {ifc.f_req_ready, ifc.l_req_ready, ifc.mem_en, ifc.mem_we}); end
    checks++; if ({ifc.f_rsp_data, ifc.l_rsp_data} !== 64'h0) begin errors++; $display("[TB] FAIL midrst_rsp_data got %h exp 0", {ifc.f_rsp_data, ifc.l_rsp_data}); end
    next_cycle();
    checks++; if (ifc.f_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_late_rsp got %b exp 0", ifc.f_rsp_valid); end
    rst = 1'b0;
    ifc.l_req_valid = 1'b0;
    #1;
    checks++; if ({ifc.f_req_ready, ifc.mem_en} !== 2'b11) begin errors++; $display("[TB] FAIL postrst_accept got %b exp 11", {ifc.f_req_ready, ifc.mem_en}); end
    next_cycle();
    ifc.f_req_valid = 1'b0;
    checks++; if ({ifc.f_rsp_valid, ifc.f_rsp_data} !== {1'b1, 32'h1234_5678}) begin errors++; $display("[TB] FAIL postrst_rsp got v%b %h exp v1 12345678", ifc.f_rsp_valid, ifc.f_rsp_data); end
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    $display("[TB] starting imem_arbiter bench");
    test_reset();
    test_fetch_basic();
    test_write_then_fetch();
    test_illegal();
    test_streak();
    test_boot_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
